// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared bitwise logic unit.
// One operation in flight at a time: accept (IDLE), compute (EXEC), hold result (RESP).

module logic_unit_bit (
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = ~(a & b);
      2'b10:   y = a | b;
      default: y = a ^ b;
    endcase
  end
endmodule

module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_q, req_sel;
  logic             prio;
  logic             grant, grant_vld, accept, rsp_hs;
  logic [WIDTH-1:0] alu_y;

  // Grant goes to prio only on contention; a lone requester always wins.
  always_comb begin
    grant_vld  = req0_valid | req1_valid;
    grant      = (req0_valid & req1_valid) ? prio : req1_valid;
    req_sel    = grant ? {req1_op, req1_a, req1_b} : {req0_op, req0_a, req0_b};
    accept     = (state == IDLE) & grant_vld;
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
    rsp_hs     = (state == RESP) & rsp_valid & rsp_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic_unit_bit u_bit (
        .op (req_q.op),
        .a  (req_q.a[gi]),
        .b  (req_q.b[gi]),
        .y  (alu_y[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      prio      <= 1'b0;
      op_count  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      if (accept) begin
        req_q  <= req_sel;
        rsp_id <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_y;
        rsp_valid <= 1'b1;
      end
      // Pointer moves only on a completed handshake, away from the requester just served.
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        prio      <= ~rsp_id;
        op_count  <= op_count + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: expected responses are queued at issue
// time and matched by a monitor on every response handshake.

module tb_logic_unit_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return ~(a & b);
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Scoreboard monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got id %0d data 0x%08h, expected none", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one request, wait for its accept, then withdraw it.
  task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    exp_t e;
    bit   ok;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    e.id = id;
    e.data = exp;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    exp_t         e;
    logic [1:0]   ops [4];
    logic [31:0]  t1_exp [4];
    logic [31:0]  a, b;
    bit           ok;

    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_op_count", {28'd0, op_count}, 32'd0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    // 1. All opcodes from requester 0
    ops    = '{2'b00, 2'b01, 2'b10, 2'b11};
    t1_exp = '{32'hF000F000, 32'h0FFF0FFF, 32'hFFF0FFF0, 32'h0FF00FF0};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ops[i], 32'hF0F0F0F0, 32'hFF00FF00, t1_exp[i]);
      wait_idle();
    end

    // 2. Fairness under continuous contention, starting from reset
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'h12345678; req0_b = 32'hFFFF0000;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h000000FF; req1_b = 32'h0F000000;
    for (int i = 0; i < 4; i++) begin
      e.id = i[0];
      e.data = i[0] ? 32'h0F0000FF : 32'hEDCB5678;
      exp_q.push_back(e);
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (op_count == 4'd4) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) check("arb_timeout", 32'd0, 32'd1);
    check("arb_op_count", {28'd0, op_count}, 32'd4);
    wait_idle();

    // 3. Backpressure: result held, new operands ignored, no accept while RESP
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(1'b0, 2'b00, 32'hDEADBEEF, 32'h0000FFFF, 32'h0000BEEF);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", rsp_data, 32'h0000BEEF);
      check("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      req0_valid = 1'b1;
      req0_op = 2'b10;
      req0_a = 32'h11111111 * (i + 1);
      req0_b = 32'hA5A5A5A5;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_back_idle", {30'd0, busy, rsp_valid}, 32'd0);

    // 4. Latency: accept in cycle 0, response in cycle 2
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'hFFFFFFFF; req1_b = 32'hFFFFFFFF;
    #1;
    check("lat_c0_req1_ready", {31'd0, req1_ready}, 32'd1);
    e.id = 1'b1;
    e.data = 32'h00000000;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("lat_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_c2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    wait_idle();

    // 5. Reset mid-RESP; prio left at 1 beforehand so the grant after reset is meaningful
    issue(1'b0, 2'b10, 32'h0000000F, 32'h000000F0, 32'h000000FF);
    wait_idle();
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(1'b1, 2'b11, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF);
    wait_rsp();
    e = exp_q.pop_back();
    do_reset();
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_op_count", {28'd0, op_count}, 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hCAFEF00D; req0_b = 32'hFFFF0000;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 32'h12345678; req1_b = 32'hFFFFFFFF;
    #1;
    check("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    e.id = 1'b0;
    e.data = 32'hCAFE0000;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();

    // 6. Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a = 32'h01020304 * (i + 3);
      b = 32'hF0E1D2C3 ^ (i << 4);
      issue(i[0], i[1:0], a, b, model(i[1:0], a, b));
      wait_idle();
    end
    check("wrap_op_count", {28'd0, op_count}, 32'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one WIDTH-bit bitwise logic unit (AND/NAND/OR/XOR) between two requesters.
- Round-robin arbitration.
- Latches the granted operands and operation, computes the result, and holds it on a valid/ready response port until it is consumed.
- Sits between the two requesting masters and the bitwise datapath. It is the only sequencer of that datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  2  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_op  input  2  requester 1 opcode.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  result.
- rsp_id  output  1  requester that issued the result.
- busy  output  1  high when state is not IDLE.
- op_count  output  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset is synchronous and active-high on rst, sampled on the rising edge of clk (single clock domain).
- Reset values:
  - state = IDLE, prio = 0, op_count = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - busy = 0, all internal operand/op registers = 0.
- Opcode: 00 AND, 01 NAND (~(A&B)), 10 OR, 11 XOR. Purely bitwise; no carries, no width growth.
- State IDLE:
  - reqN_ready is combinational: asserted only in IDLE, and only for the granted requester.
  - Both valid: grant = prio. Only one valid: that requester is granted.
  - On a grant: latch op/a/b and rsp_id = grant; next state EXEC.
  - No valid: stay in IDLE, both ready low.
- State EXEC (one cycle):
  - Compute on the latched operands and register into rsp_data.
  - Set rsp_valid = 1; next state RESP.
  - Both ready low.
- State RESP:
  - rsp_valid, rsp_data and rsp_id held stable while rsp_ready is low, for any number of cycles.
  - On rsp_valid & rsp_ready:
    - rsp_valid <= 0;
    - prio <= ~rsp_id;
    - op_count <= op_count + 1 (wraps);
    - next state IDLE.
- Latency: request accepted at edge T, rsp_valid high after edge T+1. Earliest next accept is in the cycle after the response handshake. Minimum 3 cycles per operation.
- Input changes in any state other than IDLE are ignored; operands are captured only at the accept edge.
- A requester that drops valid before being granted loses nothing and receives no response.
- The pointer prio changes only on a response handshake. A single requester may therefore be served back-to-back when the other is idle.
- Fairness: with both requesters continuously valid, grants strictly alternate, 0 first after reset.
- Reset mid-operation (EXEC or RESP): the operation is discarded and every register returns to its reset value on that edge. No response is produced for it.
- busy = (state != IDLE).

Test Plan:
1. Opcodes, requester 0 only, A=0xF0F0F0F0, B=0xFF00FF00, rsp_ready=1. Required rsp_data per op, each with rsp_id=0:
   - op 00 -> 0xF000F000
   - op 01 -> 0x0FFF0FFF
   - op 10 -> 0xFFF0FFF0
   - op 11 -> 0x0FF00FF0
2. Arbitration: both requesters held valid for 4 operations after reset -> rsp_id sequence 0,1,0,1; op_count = 4.
3. Backpressure: rsp_ready held low 5 cycles after rsp_valid, with req0 operands changed meanwhile -> rsp_data/rsp_id stable, req0_ready low throughout. Handshake on cycle 6, then return to IDLE.
4. Latency: req1_valid asserted at cycle 0 with op 01, A=B=0xFFFFFFFF -> req1_ready high in cycle 0, rsp_valid high in cycle 2, rsp_data = 0x00000000.
5. Reset mid-RESP: rst pulsed while rsp_valid=1 -> next cycle rsp_valid=0, busy=0, op_count=0. The next request from both requesters is granted to 0.
6. Counter wrap: CNT_W=4, 17 completed operations -> op_count = 1.
